reaction_game_fsm: RTL and testbench
====================================

# reaction_game_fsm

Game controller for the reaction-time benchmark. It turns the raw `keyPress` level into a four-screen game flow: start prompt, random wait, go, and result. It drives `reactScreen` and `currentScore` directly into the VGA drawing controller, which selects the background ROM and renders the four score digits from them. All timing is measured in milliseconds derived from the system clock.

## Interface
Parameters:
- `CLK_HZ`, 50_000_000, system clock frequency; must be a multiple of 1000.
- `MIN_DELAY_MS`, 1000, minimum random wait before the go screen.
- `LFSR_SEED`, 16'hACE1, LFSR reset value; must be non-zero.

Ports:
- `clk`  in  1  system clock; single clock domain.
- `iResetn`  in  1  asynchronous, active-low reset.
- `keyPress`  in  1  raw, unsynchronised key/button level; 1 = pressed.
- `reactScreen`  out  2  screen code: 0 = blue start prompt, 1 = red wait, 2 = green go, 3 = score screen.
- `currentScore`  out  12  last reaction time in ms, saturating at 4095.
- `scoreValid`  out  1  one-cycle pulse on the cycle `currentScore` is updated.
- `tooSoon`  out  1  level; 1 after a press during the red screen, cleared on the next game start.

## Operation
**Input conditioning**
- `keyPress` passes through a 2-flop synchroniser, then a rising-edge detector.
- A "press" is one cycle of `press_edge`. Holding the key produces exactly one press.

**Random source**
- 16-bit Fibonacci LFSR, taps 16, 14, 13, 11.
- Advances every cycle and never reaches zero.

**Millisecond tick (`ms_tick_gen`)**
- Prescaler counts 0..CLK_HZ/1000-1 and pulses `tick` when it wraps.
- Has a synchronous `clear` input, asserted on entry to WAIT and on entry to GO.

**States** (`reactScreen` = state code)
- IDLE (0)
  - On press: sample `delay_ms = MIN_DELAY_MS + lfsr[10:0]` (range MIN..MIN+2047), clear `tooSoon`, go to WAIT.
- WAIT (1)
  - `delay_cnt` decrements on each tick.
  - On press: set `tooSoon` and go to IDLE. Press takes priority over expiry in the same cycle.
  - When `delay_cnt` hits 0: go to GO with `ms_cnt` = 0.
- GO (2)
  - `ms_cnt` increments on each tick, saturating at 4095.
  - On press: `currentScore <= ms_cnt`, pulse `scoreValid`, go to SCORE.
  - If `ms_cnt` = 4095 and a tick arrives: `currentScore <= 4095`, pulse `scoreValid`, go to SCORE (timeout).
- SCORE (3)
  - Holds.
  - On press: go to IDLE. `currentScore` is retained.

**Widths and reset**
- `delay_cnt` is 12 bits; `ms_cnt` is 12 bits, saturating and never wrapping.
- Reset values: state IDLE (`reactScreen` = 0), `currentScore` = 0, `scoreValid` = 0, `tooSoon` = 0, LFSR = `LFSR_SEED`, synchroniser and edge flops = 0, all counters = 0.
- Reset asserted mid-game returns to IDLE immediately (asynchronously). No press is generated on reset release even if the key is held.

## Timing
- Press latency: key edge → `press_edge` takes 3 cycles (2 sync + 1 edge). State changes on the following clock edge.
- All outputs are registered. `reactScreen` changes 1 cycle after `press_edge`.
- `scoreValid` and `currentScore` update on the same edge.
- Score resolution is 1 ms, truncated: the score is the number of full ticks elapsed since GO entry. A press within the first ms scores 0.
- WAIT duration = `delay_ms` × CLK_HZ/1000 cycles (±1 cycle).
- The VGA controller samples `reactScreen` and `currentScore` once per frame; no handshake is needed because both are stable for at least one full ms.

## Structure
- Package `react_pkg` holds:
  - screen/state codes `SCR_IDLE` = 0, `SCR_WAIT` = 1, `SCR_GO` = 2, `SCR_SCORE` = 3;
  - `SCORE_MAX` = 4095;
  - LFSR tap constant.
- Sub-module `ms_tick_gen`: parameter `CLK_HZ`; ports `clk`, `iResetn`, `clear`, `tick`.
- Top level holds the synchroniser, LFSR, FSM and counters. Expected size is about 180 lines.

## Test plan
All scenarios run with `CLK_HZ` = 10_000 (10 cycles/ms), `MIN_DELAY_MS` = 5, and a fixed seed.
- **Normal round:** press → screen 1; after the computed `delay_ms` → screen 2; press 37 ms after GO → screen 3, `currentScore` = 37, one `scoreValid` pulse.
- **Early press:** press during screen 1 → screen 0, `tooSoon` = 1, `currentScore` unchanged. Next press → `tooSoon` = 0, screen 1.
- **Timeout:** no press in GO → after 4096 ms, screen 3, `currentScore` = 4095, `scoreValid` pulses once.
- **Held key:** hold `keyPress` for 100 ms from IDLE → exactly one transition to screen 1; no further transitions until release and a new press.
- **Reset mid-GO:** `iResetn` = 0 → `reactScreen` = 0 and `currentScore` = 0 without waiting for a clock. Release with the key held → stays on screen 0.
- **LFSR check:** 2^16−1 cycles from seed → LFSR returns to `LFSR_SEED` and is never 0. Sampled `delay_ms` is always within 5..2052.

Source files
------------

// File: rtl/react_pkg.sv
// react_pkg: screen/state codes, score limit and LFSR helpers for the reaction game
package react_pkg;
  typedef enum logic [1:0] {
    SCR_IDLE  = 2'd0,
    SCR_WAIT  = 2'd1,
    SCR_GO    = 2'd2,
    SCR_SCORE = 2'd3
  } scr_e;
  localparam logic [11:0] SCORE_MAX = 12'd4095;
  // Fibonacci feedback taps 16,14,13,11 (bits 15,13,12,10)
  localparam logic [15:0] LFSR_TAPS = 16'hB400;
  function automatic logic [15:0] lfsr_next(input logic [15:0] s);
    return {s[14:0], ^(s & LFSR_TAPS)};
  endfunction
endpackage

// File: rtl/ms_tick_gen.sv
// ms_tick_gen: one-cycle tick every millisecond, restartable by clear
// clk/iResetn: clock and async active-low reset; clear: restart the ms period; tick: wrap pulse
module ms_tick_gen #(
  parameter int CLK_HZ = 50_000_000
) (
  input  logic clk,
  input  logic iResetn,
  input  logic clear,
  output logic tick
);
  localparam int DIV = CLK_HZ / 1000;
  localparam int W = (DIV > 1) ? $clog2(DIV) : 1;
  logic [W-1:0] cnt_q, cnt_d;
  always_comb begin
    tick  = cnt_q == W'(DIV - 1);
    cnt_d = (clear || tick) ? '0 : cnt_q + 1'b1;
  end
  always_ff @(posedge clk or negedge iResetn)
    if (!iResetn) cnt_q <= '0;
    else          cnt_q <= cnt_d;
endmodule

// File: rtl/reaction_game_fsm.sv
// reaction_game_fsm: key conditioning, LFSR random wait and four-screen reaction-time game
// clk/iResetn: clock and async active-low reset; keyPress: raw key level
// reactScreen: screen code; currentScore: last reaction ms; scoreValid: update pulse; tooSoon: early press flag
module reaction_game_fsm
  import react_pkg::*;
#(
  parameter int          CLK_HZ       = 50_000_000,
  parameter int          MIN_DELAY_MS = 1000,
  parameter logic [15:0] LFSR_SEED    = 16'hACE1
) (
  input  logic        clk,
  input  logic        iResetn,
  input  logic        keyPress,
  output logic [1:0]  reactScreen,
  output logic [11:0] currentScore,
  output logic        scoreValid,
  output logic        tooSoon
);
  logic s1_q, s1_d, s2_q, s2_d, dly_q, dly_d, armed_q, armed_d, press_q, press_d;
  logic [1:0] prime_q, prime_d;
  logic [15:0] lfsr_q, lfsr_d;
  scr_e state_q, state_d;
  logic [11:0] delay_q, delay_d, ms_q, ms_d, score_q, score_d;
  logic valid_q, valid_d, soon_q, soon_d, clear, tick;
  ms_tick_gen #(.CLK_HZ(CLK_HZ)) u_tick (
    .clk    (clk),
    .iResetn(iResetn),
    .clear  (clear),
    .tick   (tick)
  );
  // Presses are only armed once the synchroniser has carried a real released level,
  // so a key held through reset release never counts as a press.
  always_comb begin
    s1_d    = keyPress;
    s2_d    = s1_q;
    dly_d   = s2_q;
    prime_d = {prime_q[0], 1'b1};
    armed_d = armed_q | (prime_q[1] & ~s2_q);
    press_d = armed_q & s2_q & ~dly_q;
    lfsr_d  = lfsr_next(lfsr_q);
  end
  always_comb begin
    state_d = state_q;
    delay_d = delay_q;
    ms_d    = ms_q;
    score_d = score_q;
    valid_d = 1'b0;
    soon_d  = soon_q;
    clear   = 1'b0;
    unique case (state_q)
      SCR_IDLE:
        if (press_q) begin
          delay_d = 12'(MIN_DELAY_MS) + 12'(lfsr_q[10:0]);
          soon_d  = 1'b0;
          clear   = 1'b1;
          state_d = SCR_WAIT;
        end
      SCR_WAIT:
        if (press_q) begin
          soon_d  = 1'b1;
          state_d = SCR_IDLE;
        end else if (tick) begin
          delay_d = (delay_q != 12'd0) ? delay_q - 12'd1 : 12'd0;
          if (delay_q <= 12'd1) begin
            ms_d    = 12'd0;
            clear   = 1'b1;
            state_d = SCR_GO;
          end
        end
      SCR_GO:
        if (press_q) begin
          score_d = ms_q;
          valid_d = 1'b1;
          state_d = SCR_SCORE;
        end else if (tick) begin
          ms_d = (ms_q == SCORE_MAX) ? ms_q : ms_q + 12'd1;
          if (ms_q == SCORE_MAX) begin
            score_d = SCORE_MAX;
            valid_d = 1'b1;
            state_d = SCR_SCORE;
          end
        end
      SCR_SCORE:
        state_d = press_q ? SCR_IDLE : state_q;
    endcase
  end
  always_ff @(posedge clk or negedge iResetn)
    if (!iResetn) begin
      s1_q    <= 1'b0;
      s2_q    <= 1'b0;
      dly_q   <= 1'b0;
      prime_q <= 2'b00;
      armed_q <= 1'b0;
      press_q <= 1'b0;
      lfsr_q  <= LFSR_SEED;
      state_q <= SCR_IDLE;
      delay_q <= 12'd0;
      ms_q    <= 12'd0;
      score_q <= 12'd0;
      valid_q <= 1'b0;
      soon_q  <= 1'b0;
    end else begin
      s1_q    <= s1_d;
      s2_q    <= s2_d;
      dly_q   <= dly_d;
      prime_q <= prime_d;
      armed_q <= armed_d;
      press_q <= press_d;
      lfsr_q  <= lfsr_d;
      state_q <= state_d;
      delay_q <= delay_d;
      ms_q    <= ms_d;
      score_q <= score_d;
      valid_q <= valid_d;
      soon_q  <= soon_d;
    end
  assign reactScreen  = state_q;
  assign currentScore = score_q;
  assign scoreValid   = valid_q;
  assign tooSoon      = soon_q;
endmodule

// File: tb/tb_reaction_game_fsm.sv
// tb_reaction_game_fsm: directed scenario bench for reaction_game_fsm at 10 cycles per ms
module tb_reaction_game_fsm;
  localparam logic [15:0] SEED = 16'hACE1;
  logic clk = 1'b0, iResetn = 1'b0, keyPress = 1'b0;
  logic [1:0] reactScreen;
  logic [11:0] currentScore;
  logic scoreValid, tooSoon;
  int vectors = 0, miscompares = 0;
  reaction_game_fsm #(.CLK_HZ(10_000), .MIN_DELAY_MS(5), .LFSR_SEED(SEED)) dut (
    .clk         (clk),
    .iResetn     (iResetn),
    .keyPress    (keyPress),
    .reactScreen (reactScreen),
    .currentScore(currentScore),
    .scoreValid  (scoreValid),
    .tooSoon     (tooSoon)
  );
  always #5 clk = ~clk;
  int cyc = 0, ent1 = 0, sv_cnt = 0, e_cyc = 0, g_cyc = 0, s_cyc = 0, lcnt = 0, delay_ms = 0;
  logic [1:0] scr_last = 2'd0;
  logic [15:0] m = SEED, m_prev = SEED;
  bit lfsr_bad = 1'b0, period_ok = 1'b0;
  // Observer one unit after each rising edge: cycle count, screen entries, pulses, LFSR model.
  always @(posedge clk) begin
    #1;
    cyc++;
    if (!iResetn) begin
      m = SEED; lcnt = 0; scr_last = 2'd0;
    end else begin
      m_prev = m;
      m = {m[14:0], m[15] ^ m[13] ^ m[12] ^ m[10]};
      lcnt++;
      if (dut.lfsr_q !== m || dut.lfsr_q === 16'd0) lfsr_bad = 1'b1;
      if (lcnt < 65535 && dut.lfsr_q === SEED) lfsr_bad = 1'b1;
      if (lcnt == 65535 && dut.lfsr_q === SEED) period_ok = 1'b1;
      if (scr_last != 2'd1 && reactScreen == 2'd1) begin ent1++; e_cyc = cyc; delay_ms = 5 + int'(m_prev[10:0]); end
      if (scr_last != 2'd2 && reactScreen == 2'd2) g_cyc = cyc;
      if (scr_last != 2'd3 && reactScreen == 2'd3) s_cyc = cyc;
      if (scoreValid) sv_cnt++;
      scr_last = reactScreen;
    end
  end
  task automatic press();
    keyPress = 1'b1;
    repeat (6) @(negedge clk);
    keyPress = 1'b0;
    repeat (6) @(negedge clk);
  endtask
  task automatic wait_scr(input logic [1:0] s, input int bound, output bit ok);
    int i = 0;
    while (reactScreen !== s && i < bound) begin @(negedge clk); i++; end
    ok = (reactScreen === s);
  endtask
  task automatic test_reset();
    repeat (3) @(negedge clk);
    vectors++; if (reactScreen !== 2'd0) begin miscompares++; $display("FAIL rst_screen: got %0d want 0", reactScreen); end
    vectors++; if (currentScore !== 12'd0) begin miscompares++; $display("FAIL rst_score: got %0d want 0", currentScore); end
    vectors++; if ({scoreValid, tooSoon} !== 2'b00) begin miscompares++; $display("FAIL rst_flags: got %b want 00", {scoreValid, tooSoon}); end
    vectors++; if (dut.lfsr_q !== SEED) begin miscompares++; $display("FAIL rst_lfsr: got %h want %h", dut.lfsr_q, SEED); end
    iResetn = 1'b1;
    repeat (5) @(negedge clk);
    vectors++; if (reactScreen !== 2'd0) begin miscompares++; $display("FAIL idle_hold: got %0d want 0", reactScreen); end
  endtask
  task automatic test_early_press();
    int k;
    k = cyc;
    press();
    vectors++; if (reactScreen !== 2'd1) begin miscompares++; $display("FAIL early_start: got %0d want 1", reactScreen); end
    vectors++; if (e_cyc !== k + 4) begin miscompares++; $display("FAIL press_latency: got %0d want %0d", e_cyc - k, 4); end
    press();
    vectors++; if (reactScreen !== 2'd0) begin miscompares++; $display("FAIL early_abort: got %0d want 0", reactScreen); end
    vectors++; if (tooSoon !== 1'b1) begin miscompares++; $display("FAIL early_toosoon: got %0d want 1", tooSoon); end
    vectors++; if (currentScore !== 12'd0) begin miscompares++; $display("FAIL early_score: got %0d want 0", currentScore); end
    press();
    vectors++; if ({reactScreen, tooSoon} !== 3'b010) begin miscompares++; $display("FAIL restart: got scr %0d soon %0d want 1 0", reactScreen, tooSoon); end
    press();
    vectors++; if ({reactScreen, tooSoon} !== 3'b001) begin miscompares++; $display("FAIL early_again: got scr %0d soon %0d want 0 1", reactScreen, tooSoon); end
  endtask
  task automatic test_held_and_round();
    int n1, sv0, k, exp_s, dur;
    bit ok;
    n1 = ent1; sv0 = sv_cnt;
    keyPress = 1'b1;
    repeat (1000) @(negedge clk);
    vectors++; if (ent1 - n1 !== 1) begin miscompares++; $display("FAIL held_starts: got %0d want 1", ent1 - n1); end
    vectors++; if (sv_cnt !== sv0) begin miscompares++; $display("FAIL held_valid: got %0d want %0d", sv_cnt, sv0); end
    vectors++; if (reactScreen !== 2'd1 && reactScreen !== 2'd2) begin miscompares++; $display("FAIL held_screen: got %0d want 1 or 2", reactScreen); end
    vectors++; if (tooSoon !== 1'b0) begin miscompares++; $display("FAIL held_toosoon: got %0d want 0", tooSoon); end
    keyPress = 1'b0;
    repeat (6) @(negedge clk);
    wait_scr(2'd2, 25000, ok);
    vectors++; if (!ok) begin miscompares++; $display("FAIL go_wait: got screen %0d want 2", reactScreen); end
    dur = g_cyc - e_cyc;
    vectors++; if (dur < delay_ms * 10 - 1 || dur > delay_ms * 10 + 1) begin miscompares++; $display("FAIL wait_len: got %0d want %0d", dur, delay_ms * 10); end
    while (cyc < g_cyc + 370) @(negedge clk);
    k = cyc; sv0 = sv_cnt;
    exp_s = (k + 3 - g_cyc) / 10;
    if (exp_s > 4095) exp_s = 4095;
    press();
    vectors++; if (reactScreen !== 2'd3 || s_cyc !== k + 4) begin miscompares++; $display("FAIL score_entry: got scr %0d at %0d want 3 at %0d", reactScreen, s_cyc - k, 4); end
    vectors++; if (currentScore !== 12'(exp_s)) begin miscompares++; $display("FAIL score_val: got %0d want %0d", currentScore, exp_s); end
    vectors++; if (sv_cnt - sv0 !== 1) begin miscompares++; $display("FAIL score_pulse: got %0d want 1", sv_cnt - sv0); end
    repeat (30) @(negedge clk);
    vectors++; if (reactScreen !== 2'd3) begin miscompares++; $display("FAIL score_hold: got %0d want 3", reactScreen); end
    press();
    vectors++; if (reactScreen !== 2'd0 || currentScore !== 12'(exp_s)) begin miscompares++; $display("FAIL score_exit: got scr %0d score %0d want 0 %0d", reactScreen, currentScore, exp_s); end
  endtask
  task automatic test_reset_mid_go();
    int n1, k;
    bit ok;
    press();
    wait_scr(2'd2, 25000, ok);
    vectors++; if (!ok) begin miscompares++; $display("FAIL go_wait2: got screen %0d want 2", reactScreen); end
    repeat (50) @(negedge clk);
    keyPress = 1'b1;
    #2 iResetn = 1'b0;
    #1;
    vectors++; if (reactScreen !== 2'd0 || currentScore !== 12'd0) begin miscompares++; $display("FAIL async_rst: got scr %0d score %0d want 0 0", reactScreen, currentScore); end
    @(negedge clk);
    repeat (4) @(negedge clk);
    iResetn = 1'b1;
    n1 = ent1;
    repeat (100) @(negedge clk);
    vectors++; if (reactScreen !== 2'd0 || ent1 !== n1) begin miscompares++; $display("FAIL held_release: got scr %0d starts %0d want 0 0", reactScreen, ent1 - n1); end
    keyPress = 1'b0;
    repeat (6) @(negedge clk);
    k = cyc;
    press();
    vectors++; if (reactScreen !== 2'd1 || e_cyc !== k + 4) begin miscompares++; $display("FAIL post_rst_press: got scr %0d lat %0d want 1 4", reactScreen, e_cyc - k); end
    press();
    vectors++; if (reactScreen !== 2'd0) begin miscompares++; $display("FAIL post_rst_abort: got %0d want 0", reactScreen); end
  endtask
  task automatic test_timeout();
    int sv0, dur;
    bit ok;
    sv0 = sv_cnt;
    press();
    vectors++; if (tooSoon !== 1'b0) begin miscompares++; $display("FAIL to_toosoon: got %0d want 0", tooSoon); end
    wait_scr(2'd2, 25000, ok);
    vectors++; if (!ok) begin miscompares++; $display("FAIL go_wait3: got screen %0d want 2", reactScreen); end
    dur = g_cyc - e_cyc;
    vectors++; if (dur < delay_ms * 10 - 1 || dur > delay_ms * 10 + 1 || delay_ms < 5 || delay_ms > 2052) begin miscompares++; $display("FAIL wait_len3: got %0d want %0d", dur, delay_ms * 10); end
    wait_scr(2'd3, 41100, ok);
    vectors++; if (!ok) begin miscompares++; $display("FAIL timeout_wait: got screen %0d want 3", reactScreen); end
    vectors++; if (s_cyc - g_cyc !== 40960) begin miscompares++; $display("FAIL timeout_len: got %0d want 40960", s_cyc - g_cyc); end
    vectors++; if (currentScore !== 12'd4095) begin miscompares++; $display("FAIL timeout_score: got %0d want 4095", currentScore); end
    repeat (5) @(negedge clk);
    vectors++; if (sv_cnt - sv0 !== 1) begin miscompares++; $display("FAIL timeout_pulse: got %0d want 1", sv_cnt - sv0); end
  endtask
  task automatic test_lfsr();
    int i = 0;
    while (lcnt < 65536 && i < 70000) begin @(negedge clk); i++; end
    vectors++; if (lcnt < 65536) begin miscompares++; $display("FAIL lfsr_budget: got %0d want 65536", lcnt); end
    vectors++; if (period_ok !== 1'b1) begin miscompares++; $display("FAIL lfsr_period: got %0d want 1", period_ok); end
    vectors++; if (lfsr_bad !== 1'b0) begin miscompares++; $display("FAIL lfsr_seq: got %0d want 0", lfsr_bad); end
  endtask
  initial begin
    test_reset();
    test_early_press();
    test_held_and_round();
    test_reset_mid_go();
    test_timeout();
    test_lfsr();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
